dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Arbitrates the single-port 4096-word data memory between two requesters:
//   the SP core load/store port (C) and an auxiliary loader/debug port (A).
//   Sits between the core and the data-memory macro. Serialises accesses in grant order
//   and routes each read response back to its owner. Grants back-to-back, one per cycle.
// PARAMETERS
//   ADDR_W      12  word-address width (2^ADDR_W words)
//   DATA_W      32  data width
//   ARB_MODE    0   0 = round-robin; 1 = fixed priority to C with anti-starvation
//   STARVE_MAX  4   ARB_MODE=1 only: max consecutive cycles A waits while C is granted (>=1)
// PORTS
//   clk        in   1       clock, all logic on rising edge
//   rst        in   1       synchronous reset, active-high
//   req_c      in   1       C request; hold req/we/addr/wdata stable until gnt_c
//   we_c       in   1       C: 1 = write, 0 = read
//   addr_c     in   ADDR_W  C word address
//   wdata_c    in   DATA_W  C write data
//   gnt_c      out  1       C request accepted this cycle (combinational)
//   rvalid_c   out  1       C read data valid (registered)
//   rdata_c    out  DATA_W  C read data
//   req_a, we_a, addr_a, wdata_a, gnt_a, rvalid_a, rdata_a: same as above, for A
//   mem_en     out  1       memory command valid (registered)
//   mem_we     out  1       memory write enable (registered)
//   mem_addr   out  ADDR_W  memory word address (registered)
//   mem_wdata  out  DATA_W  memory write data (registered)
//   mem_rdata  in   DATA_W  memory read data, valid 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//   Reset: all registered outputs 0; rr_last <= A (so C wins first); starve_cnt <= 0;
//   read-tag pipeline cleared. Reads in flight at reset never produce rvalid.
//   Grant (cycle T): at most one of gnt_c/gnt_a is high; gnt_x implies req_x. No grant while rst=1.
//   - Only one requester: it is granted.
//   - Both, ARB_MODE=0: grant the port not in rr_last; rr_last <= granted port.
//   - Both, ARB_MODE=1: grant C unless starve_cnt==STARVE_MAX, then grant A.
//     starve_cnt increments each cycle A requests and is not granted. It clears when A is granted
//     or when req_a is low.
//   T+1: mem_en=1, mem_we/addr/wdata = granted port's fields. With no grant, mem_en=0 and
//     mem_we=0; addr/wdata hold. Write commits at the memory's T+1 edge.
//   Reads: 2-stage owner tag {valid, port}. In T+2, rvalid_<owner>=1 (one cycle) and
//     rdata_<owner> = mem_rdata. The non-owner rdata holds its last value.
//     No rvalid is produced for writes.
//   Ordering: accesses complete in grant order. A write granted at T is visible to a read
//     granted at T+1 or later, from either port.
//   Throughput: one access per cycle, with no bubble between alternating ports or read/write mixes.
//   Requester rule: once gnt_x is seen, the next request may be presented the following cycle.
//     Dropping req_x before grant is legal; nothing is issued.
//   Mid-operation reset: pending tags flushed; mem_en=0 the cycle after rst is sampled.
//   Arbitration restarts as from reset.
//   Address width: no range check; all 2^ADDR_W addresses are legal.
// TESTING
//   1 rst=1 for 2 cycles, random req -> gnt_*/rvalid_*/mem_en all 0 throughout and after
//     until a req arrives.
//   2 C write addr 0x010 data 0xDEADBEEF at T, C read 0x010 at T+1 -> gnt_c at T and T+1;
//     mem_en at T+1/T+2; rvalid_c=1 at T+3, rdata_c=0xDEADBEEF; rvalid_a stays 0.
//   3 ARB_MODE=0, both request reads every cycle after reset (C addr 1, A addr 2)
//     -> grants C,A,C,A...; rvalid alternates C,A with mem[1],mem[2].
//   4 ARB_MODE=1, STARVE_MAX=4, both request continuously -> gnt_c for 4 cycles, gnt_a on the 5th,
//     then repeat. With req_c only -> gnt_c every cycle.
//   5 A read granted at T, rst=1 at T+1 -> rvalid_a never asserts; mem_en=0 at T+2.
//   6 ARB_MODE=0 with rr_last=C: A write 0x7 := 5 and C read 0x7 together -> A granted first,
//     C next cycle; rdata_c=5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: combinational grant,
// registered memory command, owner-tagged read return.
module dmem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int ARB_MODE   = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_c,
   input  logic              we_c,
   input  logic [ADDR_W-1:0] addr_c,
   input  logic [DATA_W-1:0] wdata_c,
   output logic              gnt_c,
   output logic              rvalid_c,
   output logic [DATA_W-1:0] rdata_c,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   output logic              gnt_a,
   output logic              rvalid_a,
   output logic [DATA_W-1:0] rdata_a,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic {PORT_C = 1'b0, PORT_A = 1'b1} port_t;

   port_t             rr_last;
   logic [SW-1:0]     starve_cnt;
   logic              tag_vld;
   port_t             tag_port;
   logic [DATA_W-1:0] hold_c;
   logic [DATA_W-1:0] hold_a;

   always_comb begin
      gnt_c = 1'b0;
      gnt_a = 1'b0;
      if (!rst) begin
         if (req_c && req_a) begin
            if (ARB_MODE == 0) gnt_a = (rr_last == PORT_C);
            else               gnt_a = (starve_cnt == SW'(STARVE_MAX));
            gnt_c = !gnt_a;
         end else begin
            gnt_c = req_c;
            gnt_a = req_a;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_last    <= PORT_A;
         starve_cnt <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         tag_vld    <= 1'b0;
         tag_port   <= PORT_C;
         rvalid_c   <= 1'b0;
         rvalid_a   <= 1'b0;
         hold_c     <= '0;
         hold_a     <= '0;
      end else begin
         mem_en <= gnt_c | gnt_a;
         mem_we <= (gnt_c & we_c) | (gnt_a & we_a);
         if (gnt_c) begin
            mem_addr  <= addr_c;
            mem_wdata <= wdata_c;
            rr_last   <= PORT_C;
         end else if (gnt_a) begin
            mem_addr  <= addr_a;
            mem_wdata <= wdata_a;
            rr_last   <= PORT_A;
         end
         // Stage 1 tag rides with the memory command, stage 2 is rvalid itself
         tag_vld  <= (gnt_c & !we_c) | (gnt_a & !we_a);
         tag_port <= gnt_a ? PORT_A : PORT_C;
         rvalid_c <= tag_vld && (tag_port == PORT_C);
         rvalid_a <= tag_vld && (tag_port == PORT_A);
         if (rvalid_c) hold_c <= mem_rdata;
         if (rvalid_a) hold_a <= mem_rdata;
         if (!req_a || gnt_a)
            starve_cnt <= '0;
         else if (starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Owner sees memory data directly in its rvalid cycle; otherwise the last value is held
   assign rdata_c = rvalid_c ? mem_rdata : hold_c;
   assign rdata_a = rvalid_a ? mem_rdata : hold_a;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances side by side,
// each with its own memory macro, checked every cycle against a grant-order model.
module tb_dmem_arbiter;

   localparam int SMAX = 4;

   logic clk = 1'b0;
   logic rst;

   logic        req_c [2], we_c [2], req_a [2], we_a [2];
   logic [11:0] addr_c [2], addr_a [2];
   logic [31:0] wdata_c [2], wdata_a [2];
   logic        gnt_c [2], gnt_a [2], rvalid_c [2], rvalid_a [2];
   logic [31:0] rdata_c [2], rdata_a [2];
   logic        mem_en [2], mem_we [2];
   logic [11:0] mem_addr [2];
   logic [31:0] mem_wdata [2], mem_rdata [2];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .ARB_MODE(0), .STARVE_MAX(SMAX)) u_rr (
      .clk(clk), .rst(rst),
      .req_c(req_c[0]), .we_c(we_c[0]), .addr_c(addr_c[0]), .wdata_c(wdata_c[0]),
      .gnt_c(gnt_c[0]), .rvalid_c(rvalid_c[0]), .rdata_c(rdata_c[0]),
      .req_a(req_a[0]), .we_a(we_a[0]), .addr_a(addr_a[0]), .wdata_a(wdata_a[0]),
      .gnt_a(gnt_a[0]), .rvalid_a(rvalid_a[0]), .rdata_a(rdata_a[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .ARB_MODE(1), .STARVE_MAX(SMAX)) u_fp (
      .clk(clk), .rst(rst),
      .req_c(req_c[1]), .we_c(we_c[1]), .addr_c(addr_c[1]), .wdata_c(wdata_c[1]),
      .gnt_c(gnt_c[1]), .rvalid_c(rvalid_c[1]), .rdata_c(rdata_c[1]),
      .req_a(req_a[1]), .we_a(we_a[1]), .addr_a(addr_a[1]), .wdata_a(wdata_a[1]),
      .gnt_a(gnt_a[1]), .rvalid_a(rvalid_a[1]), .rdata_a(rdata_a[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic logic [31:0] init_word(input logic [11:0] a);
      return 32'hA500_0000 | {20'd0, a};
   endfunction

   // Memory macros: unwritten words read back as init_word(addr)
   logic [31:0] ram [2][4096];
   bit          ram_wr [2][4096];

   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (mem_en[m] && mem_we[m]) begin
            ram[m][mem_addr[m]]    <= mem_wdata[m];
            ram_wr[m][mem_addr[m]] <= 1'b1;
         end else if (mem_en[m]) begin
            mem_rdata[m] <= ram_wr[m][mem_addr[m]] ? ram[m][mem_addr[m]] : init_word(mem_addr[m]);
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: accesses applied to a flat memory in grant order
   bit [31:0] ref_mem [2][4096];
   bit        ref_wr [2][4096];
   bit        last_was_a [2];
   int        starve [2];
   bit        e_en [2], e_we [2];
   bit [11:0] e_addr [2];
   bit [31:0] e_wd [2];
   bit [31:0] e_hold_c [2], e_hold_a [2];
   bit        rd_due [2][4];
   bit        rd_port_a [2][4];
   bit [31:0] rd_data [2][4];
   int        cyc = 0;
   bit        eg_c, eg_a, pick_a, rv_c, rv_a;
   int        slot, dslot;

   always @(negedge clk) begin
      slot  = cyc % 4;
      dslot = (cyc + 2) % 4;
      for (int m = 0; m < 2; m++) begin
         eg_c = 1'b0;
         eg_a = 1'b0;
         if (!rst) begin
            if (req_c[m] && req_a[m]) begin
               pick_a = (m == 0) ? !last_was_a[m] : (starve[m] == SMAX);
               eg_a   = pick_a;
               eg_c   = !pick_a;
            end else begin
               eg_c = req_c[m];
               eg_a = req_a[m];
            end
         end
         rv_c = rd_due[m][slot] && !rd_port_a[m][slot];
         rv_a = rd_due[m][slot] && rd_port_a[m][slot];
         check($sformatf("m%0d gnt_c", m), gnt_c[m], eg_c);
         check($sformatf("m%0d gnt_a", m), gnt_a[m], eg_a);
         check($sformatf("m%0d mem_en", m), mem_en[m], e_en[m]);
         check($sformatf("m%0d mem_we", m), mem_we[m], e_we[m]);
         check($sformatf("m%0d mem_addr", m), mem_addr[m], e_addr[m]);
         check($sformatf("m%0d mem_wdata", m), mem_wdata[m], e_wd[m]);
         check($sformatf("m%0d rvalid_c", m), rvalid_c[m], rv_c);
         check($sformatf("m%0d rvalid_a", m), rvalid_a[m], rv_a);
         check($sformatf("m%0d rdata_c", m), rdata_c[m], rv_c ? rd_data[m][slot] : e_hold_c[m]);
         check($sformatf("m%0d rdata_a", m), rdata_a[m], rv_a ? rd_data[m][slot] : e_hold_a[m]);

         if (rv_c) e_hold_c[m] = rd_data[m][slot];
         if (rv_a) e_hold_a[m] = rd_data[m][slot];
         rd_due[m][slot] = 1'b0;
         if (rst) begin
            last_was_a[m] = 1'b1;
            starve[m]     = 0;
            e_en[m]       = 1'b0;
            e_we[m]       = 1'b0;
            e_addr[m]     = '0;
            e_wd[m]       = '0;
            e_hold_c[m]   = '0;
            e_hold_a[m]   = '0;
            for (int s = 0; s < 4; s++) rd_due[m][s] = 1'b0;
         end else begin
            e_en[m] = eg_c || eg_a;
            e_we[m] = 1'b0;
            if (eg_c || eg_a) begin
               e_we[m]       = eg_a ? we_a[m] : we_c[m];
               e_addr[m]     = eg_a ? addr_a[m] : addr_c[m];
               e_wd[m]       = eg_a ? wdata_a[m] : wdata_c[m];
               last_was_a[m] = eg_a;
               if (e_we[m]) begin
                  ref_mem[m][e_addr[m]] = e_wd[m];
                  ref_wr[m][e_addr[m]]  = 1'b1;
               end else begin
                  rd_due[m][dslot]    = 1'b1;
                  rd_port_a[m][dslot] = eg_a;
                  rd_data[m][dslot]   = ref_wr[m][e_addr[m]] ? ref_mem[m][e_addr[m]]
                                                             : init_word(e_addr[m]);
               end
            end
            if (req_a[m] && !eg_a) starve[m]++;
            else                   starve[m] = 0;
         end
      end
      cyc++;
   end

   task automatic set_c(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
      for (int m = 0; m < 2; m++) begin
         req_c[m] = r; we_c[m] = w; addr_c[m] = a; wdata_c[m] = d;
      end
   endtask

   task automatic set_a(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
      for (int m = 0; m < 2; m++) begin
         req_a[m] = r; we_a[m] = w; addr_a[m] = a; wdata_a[m] = d;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pin_idle(input string nm);
      for (int m = 0; m < 2; m++) begin
         check($sformatf("%s m%0d gnt_c", nm, m), gnt_c[m], 1'b0);
         check($sformatf("%s m%0d gnt_a", nm, m), gnt_a[m], 1'b0);
         check($sformatf("%s m%0d mem_en", nm, m), mem_en[m], 1'b0);
         check($sformatf("%s m%0d rvalid_c", nm, m), rvalid_c[m], 1'b0);
         check($sformatf("%s m%0d rvalid_a", nm, m), rvalid_a[m], 1'b0);
      end
   endtask

   function automatic logic [11:0] rand_addr();
      case ($urandom_range(0, 7))
         0:       return 12'hFFF;
         1:       return 12'h000;
         default: return 12'($urandom_range(0, 15));
      endcase
   endfunction

   bit lg_c [2], lg_a [2];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      set_c(1'b0, 1'b0, '0, '0);
      set_a(1'b0, 1'b0, '0, '0);

      // Reset with random requests present, then quiet
      for (int k = 0; k < 2; k++) begin
         for (int m = 0; m < 2; m++) begin
            req_c[m] = 1'($urandom_range(0, 1));
            req_a[m] = 1'($urandom_range(0, 1));
            addr_c[m] = rand_addr();
            addr_a[m] = rand_addr();
         end
         @(negedge clk);
         pin_idle("rst");
         step();
      end
      rst = 1'b0;
      set_c(1'b0, 1'b0, '0, '0);
      set_a(1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         pin_idle("post_rst");
         step();
      end

      // C write then C read of the same word
      set_c(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
      @(negedge clk);
      check("wr_rd gnt_w", gnt_c[0], 1'b1);
      step();
      set_c(1'b1, 1'b0, 12'h010, 32'h0);
      @(negedge clk);
      check("wr_rd gnt_r", gnt_c[0], 1'b1);
      check("wr_rd en_w", mem_en[0], 1'b1);
      check("wr_rd we_w", mem_we[0], 1'b1);
      check("wr_rd addr_w", mem_addr[0], 12'h010);
      check("wr_rd wdata", mem_wdata[0], 32'hDEADBEEF);
      step();
      set_c(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("wr_rd en_r", mem_en[0], 1'b1);
      check("wr_rd we_r", mem_we[0], 1'b0);
      step();
      @(negedge clk);
      check("wr_rd rvalid_c", rvalid_c[0], 1'b1);
      check("wr_rd rdata_c", rdata_c[0], 32'hDEADBEEF);
      check("wr_rd rvalid_a", rvalid_a[0], 1'b0);

      // Continuous contention after a fresh reset
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_c(1'b1, 1'b0, 12'h001, '0);
      set_a(1'b1, 1'b0, 12'h002, '0);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check($sformatf("rr k%0d gnt_c", k), gnt_c[0], (k % 2) == 0);
         check($sformatf("rr k%0d gnt_a", k), gnt_a[0], (k % 2) == 1);
         check($sformatf("fp k%0d gnt_c", k), gnt_c[1], (k % 5) != 4);
         check($sformatf("fp k%0d gnt_a", k), gnt_a[1], (k % 5) == 4);
         if (k >= 2) begin
            check($sformatf("rr k%0d rvalid_c", k), rvalid_c[0], (k % 2) == 0);
            if ((k % 2) == 0) check($sformatf("rr k%0d rdata_c", k), rdata_c[0], 32'hA500_0001);
            else              check($sformatf("rr k%0d rdata_a", k), rdata_a[0], 32'hA500_0002);
            check($sformatf("fp k%0d rvalid_a", k), rvalid_a[1], ((k - 2) % 5) == 4);
         end
         step();
      end
      set_a(1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("fp solo k%0d gnt_c", k), gnt_c[1], 1'b1);
         step();
      end

      // A read granted, then reset before its data returns
      set_c(1'b0, 1'b0, '0, '0);
      set_a(1'b1, 1'b0, 12'h003, '0);
      @(negedge clk);
      check("flush gnt_a", gnt_a[0], 1'b1);
      step();
      rst = 1'b1;
      set_a(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("flush en_t1", mem_en[0], 1'b1);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("flush en_t2", mem_en[0], 1'b0);
      check("flush rvalid_a_t2", rvalid_a[0], 1'b0);
      step();
      @(negedge clk);
      check("flush rvalid_a_t3", rvalid_a[0], 1'b0);
      step();

      // rr_last=C, then A write and C read of the same word collide
      set_c(1'b1, 1'b0, 12'h020, '0);
      @(negedge clk);
      check("rr6 gnt_c0", gnt_c[0], 1'b1);
      step();
      set_a(1'b1, 1'b1, 12'h007, 32'd5);
      set_c(1'b1, 1'b0, 12'h007, '0);
      @(negedge clk);
      check("rr6 gnt_a", gnt_a[0], 1'b1);
      check("rr6 gnt_c1", gnt_c[0], 1'b0);
      step();
      set_a(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("rr6 gnt_c2", gnt_c[0], 1'b1);
      step();
      set_c(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("rr6 mem_addr", mem_addr[0], 12'h007);
      step();
      @(negedge clk);
      check("rr6 rvalid_c", rvalid_c[0], 1'b1);
      check("rr6 rdata_c", rdata_c[0], 32'd5);
      step();

      // Randomised traffic; each requester holds its fields until granted
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int m = 0; m < 2; m++) begin
            lg_c[m] = gnt_c[m];
            lg_a[m] = gnt_a[m];
         end
         step();
         rst = ($urandom_range(0, 249) == 0);
         for (int m = 0; m < 2; m++) begin
            if (req_c[m] && (lg_c[m] || $urandom_range(0, 15) == 0)) req_c[m] = 1'b0;
            if (!req_c[m] && $urandom_range(0, 3) != 0) begin
               req_c[m] = 1'b1;
               we_c[m] = 1'($urandom_range(0, 1));
               addr_c[m] = rand_addr();
               wdata_c[m] = $urandom;
            end
            if (req_a[m] && (lg_a[m] || $urandom_range(0, 15) == 0)) req_a[m] = 1'b0;
            if (!req_a[m] && $urandom_range(0, 2) != 0) begin
               req_a[m] = 1'b1;
               we_a[m] = 1'($urandom_range(0, 1));
               addr_a[m] = rand_addr();
               wdata_a[m] = $urandom;
            end
         end
      end
      rst = 1'b0;
      set_c(1'b0, 1'b0, '0, '0);
      set_a(1'b0, 1'b0, '0, '0);
      repeat (5) step();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
